// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined carry-lookahead adder/subtractor.
//
// Operands are split into N/BLOCK lookahead groups, and the groups are split
// into STAGES equal slices. Stage k resolves slice k using the carry
// registered by stage k-1. Upper operand bits travel forward (skewed) with
// the beat, and already-resolved low sum bits are carried forward unchanged.
// Constraints: N must be a multiple of BLOCK, and N/BLOCK must be a multiple
// of STAGES.
//
// Handshake: a beat moves on a rising edge when valid and ready are both 1.
// A single global enable en = !out_valid | out_ready advances every stage
// together, and in_ready = en. Bubbles advance like real beats, and a
// stalled pipe holds every register, including sum/cout/ovf.
//
// Optional build macro PIPE_CLA_SAT_EN: when it is defined, sum saturates
// on signed overflow (cout and ovf are unchanged). When it is undefined,
// sum is the wrapped modulo-2^N result.
module pipe_cla_adder #(
    parameter int N      = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    // W: bits resolved per stage. GPS: lookahead groups per stage.
    localparam int W   = N / STAGES;
    localparam int GPS = W / BLOCK;

    logic         en;
    logic [N-1:0] b_eff;
    logic         c0;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign b_eff    = b ^ {N{sub}};
    assign c0       = cin ^ sub;

    // Resolve one W-bit slice as a chain of BLOCK-bit lookahead groups.
    // Each bit carry is the sum-of-products of the group generate/propagate
    // terms and the group carry-in. Returns {carry_out, sum_bits}.
    function automatic logic [W:0] cla_slice(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic         ci);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         acc;
        logic         prp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int q = 0; q < GPS; q++) begin
            for (int i = 1; i <= BLOCK; i++) begin
                acc = 1'b0;
                prp = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    acc = acc | (prp & g[q*BLOCK+j]);
                    prp = prp & p[q*BLOCK+j];
                end
                c[q*BLOCK+i] = acc | (prp & c[q*BLOCK]);
            end
        end
        return {c[W], p ^ c[W-1:0]};
    endfunction

    genvar k;
    for (k = 0; k < STAGES; k++) begin : stg
        // PW: operand bits still unresolved on entry. DW: sum bits known on exit.
        localparam int PW = N - k * W;
        localparam int DW = (k + 1) * W;

        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        logic          pc;
        logic          pv;
        logic [W:0]    r;
        logic [DW-1:0] sum_raw;
        logic          v_q;
        logic          c_q;
        logic [DW-1:0] sum_q;

        if (k == 0) begin : g_src
            assign pa      = a;
            assign pb      = b_eff;
            assign pc      = c0;
            assign pv      = in_valid;
            assign sum_raw = r[W-1:0];
        end else begin : g_src
            assign pa      = stg[k-1].g_mid.a_q;
            assign pb      = stg[k-1].g_mid.b_q;
            assign pc      = stg[k-1].c_q;
            assign pv      = stg[k-1].v_q;
            assign sum_raw = {r[W-1:0], stg[k-1].sum_q};
        end

        assign r = cla_slice(pa[W-1:0], pb[W-1:0], pc);

        if (k < STAGES - 1) begin : g_mid
            logic [PW-W-1:0] a_q;
            logic [PW-W-1:0] b_q;

            // Register the slice result and skew the unresolved operand bits forward.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (en) begin
                    v_q   <= pv;
                    c_q   <= r[W];
                    sum_q <= sum_raw;
                    a_q   <= pa[PW-1:W];
                    b_q   <= pb[PW-1:W];
                end
            end
        end else begin : g_last
            logic         ovf_d;
            logic         ovf_q;
            logic [N-1:0] sum_o;

            // Carry into bit N-1 is recovered as p[N-1] ^ s[N-1].
            assign ovf_d = r[W] ^ (pa[W-1] ^ pb[W-1] ^ r[W-1]);

`ifdef PIPE_CLA_SAT_EN
            // Clamp toward the true sign on overflow: wrapped sign 1 means a positive overflow.
            always_comb begin
                sum_o = sum_raw;
                if (ovf_d) begin
                    sum_o = sum_raw[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
                end
            end
`else
            assign sum_o = sum_raw;
`endif

            // Final stage register drives the result port directly.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                    ovf_q <= 1'b0;
                end else if (en) begin
                    v_q   <= pv;
                    c_q   <= r[W];
                    sum_q <= sum_o;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].sum_q;
    assign cout      = stg[STAGES-1].c_q;
    assign ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule
